nfc_status_responder: RTL and testbench

//  Device-side responder for the NAND Read Status protocol (70h plain, 78h enhanced).

---
 rtl/nfc_status_responder.sv | 125 ++++++++++++
 tb/tb_nfc_status_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nfc_status_responder.sv
// Device-side NAND Read Status responder (70h plain, 78h enhanced).
// Decodes the CLE/ALE/WE/RE strobes and returns the status byte of the
// selected way one cycle after each accepted read strobe.
module nfc_status_responder #(
  parameter int NumberOfWays = 4,
  parameter int AddrCycles78 = 3,
  parameter int WayBits      = 2
) (
  input  logic                      iSystemClock,
  input  logic                      iReset,
  input  logic [NumberOfWays-1:0]   iCE,
  input  logic                      iCLE,
  input  logic                      iALE,
  input  logic                      iWE,
  input  logic                      iRE,
  input  logic [7:0]                iDQ,
  input  logic [8*NumberOfWays-1:0] iWayStatus,
  output logic [7:0]                oDQ,
  output logic                      oDQValid,
  output logic [WayBits-1:0]        oWaySel,
  output logic                      oCmdActive,
  output logic [15:0]               oReadCount,
  output logic                      oProtocolError
);

  // state  | meaning
  // S_IDLE | waiting for a command
  // S_ADDR | collecting 78h address bytes
  // S_STAT | answering read strobes with status
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STAT} state_t;

  localparam logic [7:0] OpStatus    = 8'h70;
  localparam logic [7:0] OpStatusEnh = 8'h78;

  state_t             state, next_state;
  logic [2:0]         addr_cnt;
  logic               ce_any, we, re, cmd_wr, addr_wr, both_wr, rd;
  logic               addr_last, rd_ok, err, is_70, is_78;
  logic [WayBits-1:0] lowest_ce, way_next;
  logic [7:0]         status_sel;

  // Strobe qualification: everything is gated by any chip enable.
  always_comb begin
    ce_any    = |iCE;
    we        = iWE & ce_any;
    re        = iRE & ce_any;
    cmd_wr    = we & iCLE & ~iALE;
    addr_wr   = we & iALE & ~iCLE;
    both_wr   = we & iCLE & iALE;
    rd        = re & ~iWE;
    is_70     = cmd_wr && (iDQ == OpStatus);
    is_78     = cmd_wr && (iDQ == OpStatusEnh);
    addr_last = (addr_cnt == 3'(AddrCycles78 - 1));
  end

  // Lowest set chip-enable index and live status byte of the selected way.
  always_comb begin
    lowest_ce  = '0;
    status_sel = '0;
    for (int k = NumberOfWays - 1; k >= 0; k--) begin
      if (iCE[k]) lowest_ce = WayBits'(k);
    end
    for (int k = 0; k < NumberOfWays; k++) begin
      if (oWaySel == WayBits'(k)) status_sel = iWayStatus[8*k +: 8];
    end
  end

  // State register.
  always_ff @(posedge iSystemClock) begin
    if (iReset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: a command aborts whatever is in progress.
  always_comb begin
    next_state = state;
    if (cmd_wr) begin
      if (is_70)      next_state = S_STAT;
      else if (is_78) next_state = S_ADDR;
      else            next_state = S_IDLE;
    end else if (addr_wr && state == S_ADDR && addr_last) begin
      next_state = S_STAT;
    end
  end

  // Output decisions: read acceptance, error detection, way selection.
  always_comb begin
    rd_ok    = rd && (state == S_STAT);
    err      = (we & re) | both_wr | (addr_wr && state != S_ADDR) |
               (rd && state != S_STAT);
    way_next = oWaySel;
    if (is_70)
      way_next = lowest_ce;
    else if (addr_wr && state == S_ADDR && addr_last)
      way_next = iDQ[WayBits-1:0];
  end

  // Registered outputs and address counter.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      oDQ            <= '0;
      oDQValid       <= 1'b0;
      oWaySel        <= '0;
      oCmdActive     <= 1'b0;
      oReadCount     <= '0;
      oProtocolError <= 1'b0;
      addr_cnt       <= '0;
    end else begin
      oDQValid       <= rd_ok;
      oProtocolError <= err;
      oWaySel        <= way_next;
      oCmdActive     <= (next_state != S_IDLE);
      if (rd_ok) oDQ <= status_sel;
      if (is_78)
        addr_cnt <= '0;
      else if (addr_wr && state == S_ADDR)
        addr_cnt <= addr_cnt + 3'd1;
      if (is_70 || is_78)
        oReadCount <= '0;
      else if (rd_ok && oReadCount != 16'hFFFF)
        oReadCount <= oReadCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_nfc_status_responder.sv
// Scoreboard bench for nfc_status_responder: stimulus pushes expected status
// bytes, a negedge monitor pops them whenever oDQValid is seen.
module tb_nfc_status_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ce = 4'b0000;
  logic        cle = 1'b0, ale = 1'b0, we = 1'b0, re = 1'b0;
  logic [7:0]  dq = 8'h00;
  logic [31:0] way_status = 32'h44_C1_22_E0;
  logic [7:0]  dq_out;
  logic        dq_valid, cmd_active, prot_err;
  logic [1:0]  way_sel;
  logic [15:0] read_count;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  nfc_status_responder #(.NumberOfWays(4), .AddrCycles78(3), .WayBits(2)) dut (
    .iSystemClock(clk), .iReset(rst), .iCE(ce), .iCLE(cle), .iALE(ale),
    .iWE(we), .iRE(re), .iDQ(dq), .iWayStatus(way_status),
    .oDQ(dq_out), .oDQValid(dq_valid), .oWaySel(way_sel),
    .oCmdActive(cmd_active), .oReadCount(read_count),
    .oProtocolError(prot_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every data pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && dq_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_data: got %0h, expected no valid pulse", dq_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dq_out !== e) begin
          miscompares++;
          $display("FAIL status_byte: got %0h, expected %0h", dq_out, e);
        end
      end
    end
  end

  task automatic strobe(input logic w, input logic r, input logic c, input logic a,
                        input logic [7:0] d);
    we = w; re = r; cle = c; ale = a; dq = d;
    @(posedge clk); #1;
    we = 0; re = 0; cle = 0; ale = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [7:0] d);  strobe(1, 0, 1, 0, d); endtask
  task automatic addr(input logic [7:0] d); strobe(1, 0, 0, 1, d); endtask
  task automatic rd_exp(input logic [7:0] e);
    exp_q.push_back(e);
    strobe(0, 1, 0, 0, 8'h00);
  endtask
  task automatic rd_bad(); strobe(0, 1, 0, 0, 8'h00); endtask

  initial begin
    // Reset values
    idle(); idle();
    chk("rst_dq", dq_out, 8'h00);
    chk("rst_valid", dq_valid, 0);
    chk("rst_waysel", way_sel, 0);
    chk("rst_cmdactive", cmd_active, 0);
    chk("rst_readcount", read_count, 0);
    chk("rst_err", prot_err, 0);
    rst = 0;

    // T1: plain 70h on way0
    ce = 4'b0001;
    cmd(8'h70);
    chk("t1_cmdactive", cmd_active, 1);
    chk("t1_waysel", way_sel, 0);
    chk("t1_err", prot_err, 0);
    idle();
    chk("t1_valid_before", dq_valid, 0);
    rd_exp(8'hE0);
    chk("t1_valid", dq_valid, 1);
    chk("t1_readcount", read_count, 1);
    idle();
    chk("t1_valid_one_cycle", dq_valid, 0);
    chk("t1_dq_hold", dq_out, 8'hE0);
    // back-to-back reads see live status
    rd_exp(8'hE0);
    way_status[7:0] = 8'h5A;
    rd_exp(8'h5A);
    chk("t1_readcount3", read_count, 3);

    // T2: enhanced 78h selecting way2
    cmd(8'h78);
    chk("t2_cmdactive", cmd_active, 1);
    chk("t2_readcount_clr", read_count, 0);
    addr(8'h00); addr(8'h00);
    chk("t2_err_addr", prot_err, 0);
    addr(8'h02);
    chk("t2_waysel", way_sel, 2);
    rd_exp(8'hC1);
    way_status[23:16] = 8'h81;
    idle();
    rd_exp(8'h81);
    chk("t2_readcount", read_count, 2);

    // T3: short address phase, read rejected
    cmd(8'h78);
    addr(8'h00); addr(8'h00);
    rd_bad();
    chk("t3_err", prot_err, 1);
    chk("t3_valid", dq_valid, 0);
    chk("t3_cmdactive", cmd_active, 1);
    idle();
    chk("t3_err_pulse", prot_err, 0);
    addr(8'h03);
    chk("t3_waysel", way_sel, 3);
    chk("t3_err_final", prot_err, 0);
    rd_exp(8'h44);

    // T4: unknown opcode returns to IDLE
    cmd(8'h90);
    chk("t4_cmdactive", cmd_active, 0);
    rd_bad();
    chk("t4_err", prot_err, 1);
    chk("t4_valid", dq_valid, 0);
    chk("t4_dq_hold", dq_out, 8'h44);
    addr(8'h01);
    chk("t4_addr_err", prot_err, 1);
    chk("t4_addr_state", cmd_active, 0);

    // T5: illegal combinations
    ce = 4'b0100;
    strobe(1, 1, 1, 0, 8'h70);
    chk("t5_we_re_err", prot_err, 1);
    chk("t5_we_re_cmd", cmd_active, 1);
    chk("t5_we_re_way", way_sel, 2);
    chk("t5_we_re_valid", dq_valid, 0);
    strobe(1, 0, 1, 1, 8'h90);
    chk("t5_cleale_err", prot_err, 1);
    chk("t5_cleale_state", cmd_active, 1);
    rd_exp(8'h81);
    chk("t5_readcount", read_count, 1);
    // deselected: strobes ignored
    ce = 4'b0000;
    cmd(8'h90);
    chk("t5_ce0_state", cmd_active, 1);
    chk("t5_ce0_err", prot_err, 0);
    rd_bad();
    chk("t5_ce0_rd_err", prot_err, 0);
    chk("t5_ce0_rd_valid", dq_valid, 0);
    // plain data write ignored silently
    ce = 4'b0100;
    strobe(1, 0, 0, 0, 8'h55);
    chk("t5_data_err", prot_err, 0);
    chk("t5_data_state", cmd_active, 1);

    // Read counter saturation
    cmd(8'h70);
    re = 1;
    for (int i = 0; i < 65537; i++) begin
      exp_q.push_back(8'h81);
      @(posedge clk);
    end
    #1 re = 0;
    chk("sat_readcount", read_count, 16'hFFFF);
    idle();

    // T6: reset in the middle of an address phase
    cmd(8'h78);
    addr(8'h00);
    rst = 1;
    idle();
    chk("t6_dq", dq_out, 8'h00);
    chk("t6_valid", dq_valid, 0);
    chk("t6_waysel", way_sel, 0);
    chk("t6_cmdactive", cmd_active, 0);
    chk("t6_readcount", read_count, 0);
    chk("t6_err", prot_err, 0);
    rst = 0;
    ce = 4'b0110;
    cmd(8'h70);
    chk("t6_waysel_lowest", way_sel, 1);
    rd_exp(8'h22);
    cmd(8'h78);
    addr(8'h00); addr(8'h00); addr(8'h03);
    chk("t6_addr_waysel", way_sel, 3);

    idle(); idle(); idle();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
